// File: rtl/clk_div_bank.sv
// Bank of programmable 50%-duty clock dividers with per-channel tick strobes.
// Divisor updates are shadowed and only take effect at a terminal count.
module clk_div_bank #(
    parameter int N_CH = 4,
    parameter int DIV_W = 16,
    parameter logic [DIV_W-1:0] DIV_RESET = '0,
    parameter int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sync,
    input  logic [N_CH-1:0]  ch_en,
    input  logic             wr_en,
    input  logic [CH_W-1:0]  wr_ch,
    input  logic [DIV_W-1:0] wr_div,
    output logic [N_CH-1:0]  clk_out,
    output logic [N_CH-1:0]  tick,
    output logic [N_CH-1:0]  pending
);

    logic wr_ok;

    // One extra bit so N_CH itself is representable when it is a power of two.
    assign wr_ok = wr_en && ({1'b0, wr_ch} < (CH_W + 1)'(N_CH));

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [DIV_W-1:0] cnt;
        logic [DIV_W-1:0] active;
        logic [DIV_W-1:0] shadow;
        logic             level;
        logic             strobe;
        logic             pend;
        logic             hit;
        logic             park;
        logic             term;
        logic             load;

        assign hit  = wr_ok && (wr_ch == CH_W'(i));
        assign park = sync || !ch_en[i];
        assign term = (cnt == active);
        assign load = park || term;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt    <= '0;
                active <= DIV_RESET;
                shadow <= DIV_RESET;
                level  <= 1'b0;
                strobe <= 1'b0;
                pend   <= 1'b0;
            end else begin
                if (park) begin
                    cnt    <= '0;
                    level  <= 1'b0;
                    strobe <= 1'b0;
                end else if (term) begin
                    cnt    <= '0;
                    level  <= ~level;
                    strobe <= 1'b1;
                end else begin
                    cnt    <= cnt + 1'b1;
                    strobe <= 1'b0;
                end
                // A load sees the pre-write shadow; a same-cycle write stays pending.
                if (load) begin
                    active <= shadow;
                end
                if (hit) begin
                    shadow <= wr_div;
                    pend   <= 1'b1;
                end else if (load) begin
                    pend   <= 1'b0;
                end
            end
        end

        assign clk_out[i] = level;
        assign tick[i]    = strobe;
        assign pending[i] = pend;
    end

endmodule

// File: tb/tb_clk_div_bank.sv
// Randomised bench for clk_div_bank against a half-period reference model.
// Directed scenarios pin the model with hand-computed timings.
module tb_clk_div_bank;

    localparam int N = 5;
    localparam int DW = 4;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          sync = 1'b0;
    logic [N-1:0]  ch_en = '0;
    logic          wr_en = 1'b0;
    logic [CW-1:0] wr_ch = '0;
    logic [DW-1:0] wr_div = '0;
    logic [N-1:0]  clk_out;
    logic [N-1:0]  tick;
    logic [N-1:0]  pending;

    int checks = 0;
    int errors = 0;
    bit cmp_on = 1'b0;

    clk_div_bank #(.N_CH(N), .DIV_W(DW), .DIV_RESET('0)) dut (
        .clk(clk), .rst_n(rst_n), .sync(sync), .ch_en(ch_en),
        .wr_en(wr_en), .wr_ch(wr_ch), .wr_div(wr_div),
        .clk_out(clk_out), .tick(tick), .pending(pending)
    );

    always #5 clk = ~clk;

    // Model: count enabled edges in the current half-period; toggle when it
    // reaches D+1, where D is the divisor latched at the previous restart.
    int     m_el[N];
    int     m_half[N];
    int     m_sh[N];
    bit [N-1:0] m_lvl;
    bit [N-1:0] m_tick;
    bit [N-1:0] m_pend;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                m_el[i] = 0;
                m_sh[i] = 0;
                m_half[i] = 1;
            end
            m_lvl = '0;
            m_tick = '0;
            m_pend = '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                bit hit;
                bit loaded;
                int old_sh;
                hit = wr_en && (int'(wr_ch) == i);
                old_sh = m_sh[i];
                loaded = 1'b0;
                if (sync || !ch_en[i]) begin
                    m_el[i] = 0;
                    m_lvl[i] = 1'b0;
                    m_tick[i] = 1'b0;
                    m_half[i] = old_sh + 1;
                    loaded = 1'b1;
                end else begin
                    m_el[i] = m_el[i] + 1;
                    if (m_el[i] == m_half[i]) begin
                        m_lvl[i] = ~m_lvl[i];
                        m_tick[i] = 1'b1;
                        m_el[i] = 0;
                        m_half[i] = old_sh + 1;
                        loaded = 1'b1;
                    end else begin
                        m_tick[i] = 1'b0;
                    end
                end
                if (hit) begin
                    m_pend[i] = 1'b1;
                    m_sh[i] = int'(wr_div);
                end else if (loaded) begin
                    m_pend[i] = 1'b0;
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s at %0t: got %0d expected %0d",
                         name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_on) begin
            chk("model clk_out", int'(clk_out), int'(m_lvl));
            chk("model tick", int'(tick), int'(m_tick));
            chk("model pending", int'(pending), int'(m_pend));
        end
    end

    // Called at a negedge; returns edges until clk_out[idx] changes.
    task automatic wait_toggle(input int idx, output int n);
        logic v;
        v = clk_out[idx];
        n = 0;
        while (clk_out[idx] == v && n < 100) begin
            @(negedge clk);
            wr_en = 1'b0;
            n++;
        end
        if (clk_out[idx] == v) begin
            errors++;
            $display("FAIL timeout ch%0d: no toggle after %0d edges", idx, n);
        end
    endtask

    task automatic wr(input int ch, input int d);
        wr_en = 1'b1;
        wr_ch = CW'(ch);
        wr_div = DW'(d);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    int n;

    initial begin
        repeat (3) @(negedge clk);
        chk("reset clk_out", int'(clk_out), 0);
        chk("reset tick", int'(tick), 0);
        chk("reset pending", int'(pending), 0);
        cmp_on = 1'b1;
        rst_n = 1'b1;
        @(negedge clk);

        // T1: D=0 toggles every edge, tick stuck high
        wr(0, 0);
        ch_en = 5'b00001;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("t1 tick0", int'(tick[0]), 1);
            chk("t1 clk0", int'(clk_out[0]), (k % 2 == 0) ? 1 : 0);
        end

        // T2: D=3 first toggle on 4th enabled edge, then half-period 4
        wr(1, 3);
        @(negedge clk);
        ch_en[1] = 1'b1;
        wait_toggle(1, n);
        chk("t2 first toggle", n, 4);
        wait_toggle(1, n);
        chk("t2 half", n, 4);
        wait_toggle(1, n);
        chk("t2 half b", n, 4);

        // T3: write D=1 one edge into a D=3 high phase
        wr(1, 1);
        chk("t3 pending set", int'(pending[1]), 1);
        wait_toggle(1, n);
        chk("t3 old half rest", n, 3);
        chk("t3 pending clr", int'(pending[1]), 0);
        wait_toggle(1, n);
        chk("t3 new half", n, 2);
        wait_toggle(1, n);
        chk("t3 new half b", n, 2);

        // T4: write D=5 on the terminal edge of D=2
        wr(2, 2);
        @(negedge clk);
        ch_en[2] = 1'b1;
        wait_toggle(2, n);
        chk("t4 first", n, 3);
        @(negedge clk);
        @(negedge clk);
        wr_en = 1'b1;
        wr_ch = 3'd2;
        wr_div = 4'd5;
        wait_toggle(2, n);
        chk("t4 terminal write", n, 1);
        chk("t4 pending held", int'(pending[2]), 1);
        wait_toggle(2, n);
        chk("t4 old half", n, 3);
        chk("t4 pending clr", int'(pending[2]), 0);
        wait_toggle(2, n);
        chk("t4 new half", n, 6);

        // T5: two D=1 channels out of phase, realigned by sync
        ch_en[1:0] = 2'b00;
        wr(0, 1);
        @(negedge clk);
        ch_en[0] = 1'b1;
        @(negedge clk);
        ch_en[1] = 1'b1;
        repeat (5) @(negedge clk);
        sync = 1'b1;
        @(negedge clk);
        sync = 1'b0;
        chk("t5 parked", int'(clk_out[1:0]), 0);
        chk("t5 tick parked", int'(tick[1:0]), 0);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            chk("t5 clk0", int'(clk_out[0]), (k / 2) % 2);
            chk("t5 clk1", int'(clk_out[1]), (k / 2) % 2);
        end

        // Maximum divisor wraps through the terminal count
        wr(3, 15);
        @(negedge clk);
        ch_en[3] = 1'b1;
        wait_toggle(3, n);
        chk("max first", n, 16);
        wait_toggle(3, n);
        chk("max half", n, 16);

        // Random traffic with a mid-run async reset
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (c == 1500) begin
                ch_en = '1;
                wr_en = 1'b0;
                sync = 1'b0;
                @(posedge clk);
                #2;
                rst_n = 1'b0;
                #1;
                chk("t6 async clk_out", int'(clk_out), 0);
                chk("t6 async tick", int'(tick), 0);
                chk("t6 async pending", int'(pending), 0);
                @(negedge clk);
                rst_n = 1'b1;
                wr_en = 1'b1;
                wr_ch = 3'd5;
                wr_div = 4'd9;
                @(negedge clk);
                wr_ch = 3'd7;
                @(negedge clk);
                wr_en = 1'b0;
                chk("t6 oor pending", int'(pending), 0);
                for (int k = 1; k <= 4; k++) begin
                    @(negedge clk);
                    chk("t6 oor d0", int'(clk_out), (k % 2 == 1) ? 5'h1f : 5'h00);
                end
            end
            wr_en = ($urandom_range(0, 3) == 0);
            wr_ch = CW'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0)
                wr_div = DW'($urandom_range(0, 15));
            else
                wr_div = DW'($urandom_range(0, 3));
            sync = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 15) == 0)
                ch_en = N'($urandom);
        end

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
